// File: rtl/ps2_rx_frame_pkg.sv
// rtl/ps2_rx_frame_pkg.sv - shared types and constants for the PS/2 frame receiver
package ps2_rx_frame_pkg;

  localparam int FRAME_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

endpackage

// File: rtl/ps2_rx_frame_if.sv
// rtl/ps2_rx_frame_if.sv - received-byte handshake: data with valid or error pulse
interface ps2_rx_frame_if;
  import ps2_rx_frame_pkg::*;

  logic [FRAME_DATA_BITS-1:0] data;
  logic                       valid;
  logic                       error;

  modport master (output data, output valid, output error);
  modport slave  (input  data, input  valid, input  error);

endinterface

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchroniser, run-length hysteresis filter and falling-edge strobe
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic fall_strobe
);

  localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

  logic          sync1;
  logic          sync2;
  logic          line_filt;
  logic [CW-1:0] run_cnt;

  // Everything presets high so leaving reset on an idle line never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      line_filt   <= 1'b1;
      run_cnt     <= '0;
      fall_strobe <= 1'b0;
    end else begin
      sync1       <= line_in;
      sync2       <= sync1;
      fall_strobe <= 1'b0;
      if (sync2 == line_filt) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_LAST) begin
        line_filt   <= sync2;
        run_cnt     <= '0;
        fall_strobe <= ~sync2;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver emitting one byte per 11-bit frame
module ps2_rx_frame
  import ps2_rx_frame_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 54000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  ps2_rx_frame_if.master  rx
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int BW = $clog2(FRAME_DATA_BITS);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_DATA_BITS - 1);

  logic                       strobe;
  logic                       data_sync1, data_sync2;
  ps2_state_e                 state, state_n;
  logic [BW-1:0]              bit_cnt, bit_cnt_n;
  logic [FRAME_DATA_BITS-1:0] sr, sr_n;
  logic                       parity_ok, parity_ok_n;
  logic [TW-1:0]              to_cnt, to_cnt_n;
  logic [FRAME_DATA_BITS-1:0] data_q, data_n;
  logic                       valid_q, valid_n;
  logic                       error_q, error_n;
  logic                       timeout_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk         (clk),
    .reset       (reset),
    .line_in     (ps2_clk),
    .fall_strobe (strobe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_sync1 <= 1'b1;
      data_sync2 <= 1'b1;
      state      <= IDLE;
      bit_cnt    <= '0;
      sr         <= '0;
      parity_ok  <= 1'b0;
      to_cnt     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      data_sync1 <= ps2_data;
      data_sync2 <= data_sync1;
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      sr         <= sr_n;
      parity_ok  <= parity_ok_n;
      to_cnt     <= to_cnt_n;
      data_q     <= data_n;
      valid_q    <= valid_n;
      error_q    <= error_n;
    end
  end

  assign timeout_hit = (state != IDLE) && (to_cnt == TO_LAST);

  // A timeout takes priority over a strobe landing in the same cycle.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    sr_n        = sr;
    parity_ok_n = parity_ok;
    data_n      = data_q;
    valid_n     = 1'b0;
    error_n     = 1'b0;
    to_cnt_n    = to_cnt;

    if (state == IDLE || strobe) begin
      to_cnt_n = '0;
    end else if (to_cnt != {TW{1'b1}}) begin
      to_cnt_n = to_cnt + 1'b1;
    end

    if (timeout_hit) begin
      error_n  = 1'b1;
      state_n  = IDLE;
      to_cnt_n = '0;
    end else if (strobe) begin
      unique case (state)
        IDLE: begin
          if (!data_sync2) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          sr_n      = {data_sync2, sr[FRAME_DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) state_n = PARITY;
        end
        PARITY: begin
          parity_ok_n = ^{sr, data_sync2};
          state_n     = STOP;
        end
        STOP: begin
          if (data_sync2 && parity_ok) begin
            data_n  = sr;
            valid_n = 1'b1;
          end else begin
            error_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign rx.data  = data_q;
  assign rx.valid = valid_q;
  assign rx.error = error_q;

endmodule
